keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream input stage for the Morse encoder/decoder datapath.
- Scans the 4x4 matrix keypad by driving columns and sampling rows.
- Synchronizes and debounces the press, then emits one key code with a single-cycle strobe; the mode controller and both the encoder and decoder consume it.
- Replaces free-running ad-hoc scanning with a defined press/release state machine.

Parameters:
- SCAN_DIV, 100000: clk cycles per scan tick; 1 kHz at 100 MHz. Must be ≥ 2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a press or a release. Must be ≥ 1.
- REPEAT_DELAY_TICKS, 500: ticks a key is held before the first auto-repeat. Used only with the macro.
- REPEAT_RATE_TICKS, 150: ticks between later auto-repeats. Used only with the macro.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets the block.
- row  input  4  keypad rows; active-low with external pull-ups; row[0] is the top row.
- col  output  4  keypad column drive; active-low, one-hot-low; col[0] is the leftmost column.
- value  output  4  code of the last accepted key.
- key_flag  output  1  one-cycle pulse: value is new or repeated.
- key_held  output  1  high while an accepted key is still pressed.

Behaviour:
- Reset values:
  - col=4'b1110, value=4'h0, key_flag=0, key_held=0.
  - Scan index=0, tick counter=0, debounce counter=0.
  - Synchronizer flops=4'hF. State=SCAN.
- Input sync: row passes through a 2-flop synchronizer to give rs. All decisions use rs and are taken only on the cycle a tick occurs.
- Tick: the divider counts 0..SCAN_DIV-1. The tick is asserted for one cycle when the count wraps. The divider runs in all states.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits 0-9 → 0..9; A=10, B=11, C=12, D=13, *=14, #=15.
- SCAN state, on each tick:
  - rs==4'hF: advance the index (3 wraps to 0) and drive the new column.
  - Exactly one rs bit low: latch the row pattern, keep the column, clear the counter, go to DEBOUNCE.
  - Two or more bits low: ghost/invalid; advance the index and emit no flag.
- DEBOUNCE state, on each tick:
  - rs equals the latched pattern: increment the counter.
  - When the counter reaches DEBOUNCE_TICKS-1 on a matching tick: go to HELD.
    - In the next cycle, value is set to the mapped code and key_flag=1 for exactly one cycle.
    - key_held=1 from that same cycle.
  - Any mismatch: return to SCAN, advance the index, no flag.
- HELD state:
  - On a tick with rs==4'hF: clear the counter and go to RELEASE.
  - Otherwise stay; the column is held.
- RELEASE state, on each tick:
  - rs==4'hF: increment the counter; at DEBOUNCE_TICKS-1, set key_held=0, go to SCAN, advance the index.
  - rs equals the latched pattern: return to HELD, no new flag.
  - Any other rs: treat as released bounce; keep counting only on 4'hF ticks.
- Latency:
  - Press accepted DEBOUNCE_TICKS ticks after first detection.
  - key_flag occurs 1 clk after the accepting tick.
- value holds its code across release; it changes only on an accepted press (or a repeat).
- A second key pressed while one is held is ignored until full release.
- rst asserted mid-operation returns all outputs to reset values immediately. A key still physically down after rst deasserts is re-detected and re-flagged; this is required behaviour.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs on ticks.
  - After REPEAT_DELAY_TICKS, key_flag pulses again with the same value, then every REPEAT_RATE_TICKS until release.
  - The counter clears on entering HELD.
- Undefined: exactly one key_flag per press. The repeat counter and its parameters are not synthesized.

Decomposition:
- Package keypad_pkg:
  - State enum: SCAN, DEBOUNCE, HELD, RELEASE.
  - 4-bit key code constants KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15.
  - The row/col-to-code map function.
- One sub-module: scan_tick_gen, a parameterized divider producing the one-cycle tick.

Test Plan:
- Bench setup: SCAN_DIV=4, DEBOUNCE_TICKS=3, behavioural keypad model connecting col to row.
- Reset: hold rst=0 → col=1110, value=0, key_flag=0, key_held=0. Release rst → col cycles 1110→1101→1011→0111→1110, one step per 4 clks.
- Press "5" (r1,c1):
  - Exactly one key_flag with value=5; key_held=1.
  - Release: key_held=0 after 3 quiet ticks, no second flag.
- Bounce: press "9" for 1 tick, then release → no key_flag, scanning resumes. Later "#" → value=15; "D" → value=13.
- Ghost/multi-key:
  - r0 and r2 low in column 0 → no flag.
  - Hold "A" and press "3" → only A flagged (value=10); 3 is ignored until A is released.
- Reset mid-HELD: assert rst while "7" is held → outputs reset in the same cycle. After deassert, with 7 still held → one new flag, value=7.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2: hold "0" for 12 ticks after accept → flags at accept, +5, +7, +9, +11 ticks, all value=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key codes and matrix helpers for the keypad scanner.
// Used by keypad_scanner; the KEYPAD_REPEAT_EN option lives in the top.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Row r / column c of the matrix to its key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code_s;
    case ({r, c})
      4'd0:    code_s = KEY_1;
      4'd1:    code_s = KEY_2;
      4'd2:    code_s = KEY_3;
      4'd3:    code_s = KEY_A;
      4'd4:    code_s = KEY_4;
      4'd5:    code_s = KEY_5;
      4'd6:    code_s = KEY_6;
      4'd7:    code_s = KEY_B;
      4'd8:    code_s = KEY_7;
      4'd9:    code_s = KEY_8;
      4'd10:   code_s = KEY_9;
      4'd11:   code_s = KEY_C;
      4'd12:   code_s = KEY_STAR;
      4'd13:   code_s = KEY_0;
      4'd14:   code_s = KEY_HASH;
      default: code_s = KEY_D;
    endcase
    return code_s;
  endfunction

  function automatic logic single_low(input logic [3:0] pat);
    logic one_s;
    case (pat)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_s = 1'b1;
      default:                            one_s = 1'b0;
    endcase
    return one_s;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] pat);
    logic [1:0] idx_s;
    case (pat)
      4'b1110: idx_s = 2'd0;
      4'b1101: idx_s = 2'd1;
      4'b1011: idx_s = 2'd2;
      4'b0111: idx_s = 2'd3;
      default: idx_s = 2'd0;
    endcase
    return idx_s;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] col_s;
    case (idx)
      2'd0:    col_s = 4'b1110;
      2'd1:    col_s = 4'b1101;
      2'd2:    col_s = 4'b1011;
      default: col_s = 4'b0111;
    endcase
    return col_s;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle registered tick every DIV clocks.
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Divider count and wrap strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchronizer, debounce and press/release FSM.
// Optional auto-repeat while held when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_DELAY_TICKS = 500
  , parameter int REPEAT_RATE_TICKS  = 150
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       key_flag,
  output logic       key_held
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  state_e        state_r;
  logic [1:0]    idx_r;
  logic [3:0]    col_r;
  logic [3:0]    pat_r;
  logic [DW-1:0] deb_cnt_r;
  logic [3:0]    value_r;
  logic          key_flag_r;
  logic          key_held_r;
  logic [3:0]    sync1_r;
  logic [3:0]    rs_r;
  logic          tick_s;
  logic [1:0]    idx_next_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);
  logic [RW-1:0] rep_cnt_r;
  logic          rep_first_r;
  logic [RW-1:0] rep_limit_s;
  assign rep_limit_s = rep_first_r ? DELAY_LAST : RATE_LAST;
`endif

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign idx_next_s = idx_r + 2'd1;

  // Row synchronizer and press/release state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= SCAN;
      idx_r       <= 2'd0;
      col_r       <= 4'b1110;
      pat_r       <= 4'hF;
      deb_cnt_r   <= '0;
      value_r     <= 4'h0;
      key_flag_r  <= 1'b0;
      key_held_r  <= 1'b0;
      sync1_r     <= 4'hF;
      rs_r        <= 4'hF;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= '0;
      rep_first_r <= 1'b1;
`endif
    end else begin
      sync1_r    <= row;
      rs_r       <= sync1_r;
      key_flag_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          SCAN: begin
            if (rs_r != ROWS_IDLE && single_low(rs_r)) begin
              pat_r     <= rs_r;
              deb_cnt_r <= '0;
              state_r   <= DEBOUNCE;
            end else begin
              // idle rows and ghosted multi-key patterns both just move on
              idx_r <= idx_next_s;
              col_r <= col_drive(idx_next_s);
            end
          end
          DEBOUNCE: begin
            if (rs_r == pat_r) begin
              if (deb_cnt_r == DEB_LAST) begin
                state_r    <= HELD;
                value_r    <= key_map(low_index(pat_r), idx_r);
                key_flag_r <= 1'b1;
                key_held_r <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_r   <= '0;
                rep_first_r <= 1'b1;
`endif
              end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
              end
            end else begin
              state_r <= SCAN;
              idx_r   <= idx_next_s;
              col_r   <= col_drive(idx_next_s);
            end
          end
          HELD: begin
            if (rs_r == ROWS_IDLE) begin
              deb_cnt_r <= '0;
              state_r   <= RELEASE;
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt_r == rep_limit_s) begin
                rep_cnt_r   <= '0;
                rep_first_r <= 1'b0;
                key_flag_r  <= 1'b1;
              end else begin
                rep_cnt_r <= rep_cnt_r + RW'(1);
              end
`else
              state_r <= HELD;
`endif
            end
          end
          RELEASE: begin
            if (rs_r == ROWS_IDLE) begin
              if (deb_cnt_r == DEB_LAST) begin
                key_held_r <= 1'b0;
                state_r    <= SCAN;
                idx_r      <= idx_next_s;
                col_r      <= col_drive(idx_next_s);
              end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
              end
            end else if (rs_r == pat_r) begin
              state_r <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r   <= '0;
              rep_first_r <= 1'b1;
`endif
            end else begin
              state_r <= RELEASE;
            end
          end
          default: state_r <= SCAN;
        endcase
      end
    end
  end

  assign col      = col_r;
  assign value    = value_r;
  assign key_flag = key_flag_r;
  assign key_held = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3).
// Define KEYPAD_REPEAT_EN to also exercise auto-repeat (delay 5, rate 2).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] value;
  logic       key_flag;
  logic       key_held;
  logic [15:0] keys = 16'h0000;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY_TICKS(5)
    , .REPEAT_RATE_TICKS(2)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .value    (value),
    .key_flag (key_flag),
    .key_held (key_held)
  );

  // Keypad model: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (key_flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_flag: got value %0h expected no flag", value);
      end else begin
        check("flag_value", {4'h0, value}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    keys[r*4+c] = 1'b0;
  endtask

  task automatic wait_held(input logic want, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (key_held == want) break;
    end
    check(name, {7'd0, key_held}, {7'd0, want});
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] exp_cols [4];
    int n;
    exp_cols[0] = 4'b1101; exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111; exp_cols[3] = 4'b1110;

    repeat (3) @(negedge clk);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_value", {4'h0, value}, 8'h00);
    check("rst_flag", {7'd0, key_flag}, 8'h00);
    check("rst_held", {7'd0, key_held}, 8'h00);
    rst = 1'b1;

    prev = col;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        n++;
        if (col != prev) break;
      end
      check("col_step", {4'h0, col}, {4'h0, exp_cols[k]});
      if (k > 0) check("col_period", 8'(n), 8'd4);
      prev = col;
    end

    // Key 5, then release with no second flag.
    exp_q.push_back(4'd5);
    press(1, 1);
    wait_held(1'b1, "held_5");
    check("value_5", {4'h0, value}, 8'h05);
    release_key(1, 1);
    wait_held(1'b0, "release_5");
    repeat (40) @(negedge clk);
    check("value_kept_5", {4'h0, value}, 8'h05);

    // Short bounce on 9: nothing accepted, scanning continues.
    press(2, 2);
    repeat (4) @(negedge clk);
    release_key(2, 2);
    repeat (40) @(negedge clk);
    check("bounce_held", {7'd0, key_held}, 8'h00);
    prev = col;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col != prev) break;
    end
    check("bounce_scan_resumes", {7'd0, col != prev}, 8'h01);

    exp_q.push_back(4'd15);
    press(3, 2);
    wait_held(1'b1, "held_hash");
    release_key(3, 2);
    wait_held(1'b0, "release_hash");

    exp_q.push_back(4'd13);
    press(3, 3);
    wait_held(1'b1, "held_d");
    release_key(3, 3);
    wait_held(1'b0, "release_d");

    // Ghost: two rows low in column 0.
    press(0, 0);
    press(2, 0);
    repeat (120) @(negedge clk);
    check("ghost_held", {7'd0, key_held}, 8'h00);
    release_key(0, 0);
    release_key(2, 0);
    repeat (20) @(negedge clk);

    // Hold A, press 3: 3 only accepted after A is released.
    exp_q.push_back(4'd10);
    press(0, 3);
    wait_held(1'b1, "held_a");
    press(0, 2);
    repeat (80) @(negedge clk);
    check("a_still_value", {4'h0, value}, 8'h0A);
    exp_q.push_back(4'd3);
    release_key(0, 3);
    wait_held(1'b0, "release_a");
    wait_held(1'b1, "held_3");
    check("value_3", {4'h0, value}, 8'h03);
    release_key(0, 2);
    wait_held(1'b0, "release_3");

    // Reset while 7 is held; 7 is re-detected afterwards.
    exp_q.push_back(4'd7);
    press(2, 0);
    wait_held(1'b1, "held_7");
    rst = 1'b0;
    #1;
    check("midrst_col", {4'h0, col}, 8'h0E);
    check("midrst_value", {4'h0, value}, 8'h00);
    check("midrst_flag", {7'd0, key_flag}, 8'h00);
    check("midrst_held", {7'd0, key_held}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'd7);
    wait_held(1'b1, "reheld_7");
    check("value_7", {4'h0, value}, 8'h07);
    release_key(2, 0);
    wait_held(1'b0, "release_7");

`ifdef KEYPAD_REPEAT_EN
    // Hold 0: flags at accept, +5, +7, +9, +11 ticks.
    for (int i = 0; i < 5; i++) exp_q.push_back(4'd0);
    press(3, 1);
    wait_held(1'b1, "held_0");
    repeat (45) @(posedge clk);
    @(negedge clk);
    release_key(3, 1);
    wait_held(1'b0, "release_0");
`endif

    repeat (100) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
